// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the MEM pipeline stage.
//   mem_state_t      : data-memory access FSM states
//   WB_SEL_EXEC/MEM  : write-back source select encodings
//   WORD_ALIGN_MASK  : address bits that must be zero for a word access
//   is_misaligned()  : word-alignment test on a byte address
// ----------------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic        WB_SEL_EXEC     = 1'b0;
  localparam logic        WB_SEL_MEM      = 1'b1;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  // True when a byte address does not point at the start of a 32-bit word.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return ((addr & WORD_ALIGN_MASK) != 32'h0000_0000);
  endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// ----------------------------------------------------------------------------
// dmem_access_fsm
// Sequences one data-memory access over a variable-latency req/ack port.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   i_start            : aligned load/store present in the M register
//   i_ack              : memory completes the access this cycle
//   o_req              : memory request (combinational, held until ack)
//   o_stall            : freeze upstream and hold the M register
//   o_timeout_pulse    : access abandoned this cycle (WB must bubble)
//   o_timeout          : sticky abandonment flag, cleared only by reset
// ----------------------------------------------------------------------------
module dmem_access_fsm
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_ack,
  output logic o_req,
  output logic o_stall,
  output logic o_timeout_pulse,
  output logic o_timeout
);

  // Wide enough to hold MAX_WAIT-1 for any MAX_WAIT >= 1.
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  mem_state_t    r_state;
  mem_state_t    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // State register, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= {CW{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counter only runs across consecutive BUSY cycles; any exit clears it.
      if ((r_state == BUSY) && (w_next == BUSY)) begin
        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= {CW{1'b0}};
      end
      if (o_timeout_pulse) begin
        r_timeout <= 1'b1;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  // Next-state, request and stall decode.
  always_comb begin
    w_next          = r_state;
    o_req           = 1'b0;
    o_stall         = 1'b0;
    o_timeout_pulse = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          o_req = 1'b1;
          // Same-cycle ack completes with no extra latency.
          if (i_ack) begin
            w_next  = IDLE;
            o_stall = 1'b0;
          end else begin
            w_next  = BUSY;
            o_stall = 1'b1;
          end
        end else begin
          // Stray acks with nothing outstanding are ignored.
          w_next = IDLE;
        end
      end
      BUSY: begin
        o_req = 1'b1;
        if (i_ack) begin
          w_next  = IDLE;
          o_stall = 1'b0;
        end else if (r_cnt == LAST_WAIT) begin
          w_next          = IDLE;
          o_stall         = 1'b0;
          o_timeout_pulse = 1'b1;
        end else begin
          w_next  = BUSY;
          o_stall = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign o_timeout = r_timeout;

endmodule

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
// MEM pipeline stage: EX/MEM register, forwarding output, word load/store
// over a req/ack data-memory port, and the MEM/WB register.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   execute_out_e           : ALU/PC result; byte address for loads/stores
//   reg_readdata2_m         : store data
//   reg_write_addr_m/_en_m  : destination register and write enable
//   dmem_read_en_m          : load
//   dmem_write_en_m         : store (wins when both are set)
//   reg_writedata_sel_m     : WB source, 0=execute result, 1=load data
//   execute_out_m           : registered execute_out_e (forwarding)
//   stall_m                 : freeze upstream, hold M register
//   dmem_req/we/addr/wdata  : data-memory request side
//   dmem_ack/rdata          : data-memory response side
//   reg_writedata_w/addr_w/en_w : registered write-back
//   mem_misalign_w          : one-cycle pulse, misaligned access dropped
//   mem_timeout             : sticky, access abandoned after MAX_WAIT
// ----------------------------------------------------------------------------
module memory_stage
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] execute_out_e,
  input  logic [31:0] reg_readdata2_m,
  input  logic [4:0]  reg_write_addr_m,
  input  logic        reg_write_en_m,
  input  logic        dmem_read_en_m,
  input  logic        dmem_write_en_m,
  input  logic        reg_writedata_sel_m,
  output logic [31:0] execute_out_m,
  output logic        stall_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] reg_writedata_w,
  output logic [4:0]  reg_write_addr_w,
  output logic        reg_write_en_w,
  output logic        mem_misalign_w,
  output logic        mem_timeout
);

  // M register
  logic [31:0] r_exec_out;
  logic [31:0] r_store_data;
  logic [4:0]  r_waddr;
  logic        r_wen;
  logic        r_rd;
  logic        r_wr;
  logic        r_sel;

  // WB register
  logic [31:0] r_wb_data;
  logic [4:0]  r_wb_addr;
  logic        r_wb_en;
  logic        r_wb_misalign;

  logic w_mem_op;
  logic w_misalign;
  logic w_start;
  logic w_req;
  logic w_stall;
  logic w_timeout_pulse;
  logic w_timeout;

  assign w_mem_op   = r_rd | r_wr;
  assign w_misalign = w_mem_op & is_misaligned(r_exec_out);
  assign w_start    = w_mem_op & ~w_misalign;

  dmem_access_fsm #(
    .MAX_WAIT (MAX_WAIT)
  ) u_fsm (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (w_start),
    .i_ack           (dmem_ack),
    .o_req           (w_req),
    .o_stall         (w_stall),
    .o_timeout_pulse (w_timeout_pulse),
    .o_timeout       (w_timeout)
  );

  // EX/MEM register: loads whenever the stage is not stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exec_out   <= 32'h0000_0000;
      r_store_data <= 32'h0000_0000;
      r_waddr      <= 5'd0;
      r_wen        <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_sel        <= WB_SEL_EXEC;
    end else if (!w_stall) begin
      r_exec_out   <= execute_out_e;
      r_store_data <= reg_readdata2_m;
      r_waddr      <= reg_write_addr_m;
      r_wen        <= reg_write_en_m;
      r_rd         <= dmem_read_en_m;
      r_wr         <= dmem_write_en_m;
      r_sel        <= reg_writedata_sel_m;
    end else begin
      r_exec_out   <= r_exec_out;
      r_store_data <= r_store_data;
      r_waddr      <= r_waddr;
      r_wen        <= r_wen;
      r_rd         <= r_rd;
      r_wr         <= r_wr;
      r_sel        <= r_sel;
    end
  end

  // MEM/WB register: bubbles while stalled; stores, misaligned accesses
  // and abandoned accesses never write the register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wb_data     <= 32'h0000_0000;
      r_wb_addr     <= 5'd0;
      r_wb_en       <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else if (w_stall) begin
      r_wb_data     <= 32'h0000_0000;
      r_wb_addr     <= 5'd0;
      r_wb_en       <= 1'b0;
      r_wb_misalign <= 1'b0;
    end else begin
      r_wb_data     <= (r_sel == WB_SEL_MEM) ? dmem_rdata : r_exec_out;
      r_wb_addr     <= r_waddr;
      r_wb_en       <= r_wen & ~r_wr & ~w_misalign & ~w_timeout_pulse;
      r_wb_misalign <= w_misalign;
    end
  end

  assign execute_out_m    = r_exec_out;
  assign stall_m          = w_stall;
  assign dmem_req         = w_req;
  assign dmem_we          = w_req & r_wr;
  assign dmem_addr        = {r_exec_out[31:2], 2'b00};
  assign dmem_wdata       = r_store_data;
  assign reg_writedata_w  = r_wb_data;
  assign reg_write_addr_w = r_wb_addr;
  assign reg_write_en_w   = r_wb_en;
  assign mem_misalign_w   = r_wb_misalign;
  assign mem_timeout      = w_timeout;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a write-back scoreboard.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] execute_out_e;
  logic [31:0] reg_readdata2_m;
  logic [4:0]  reg_write_addr_m;
  logic        reg_write_en_m;
  logic        dmem_read_en_m;
  logic        dmem_write_en_m;
  logic        reg_writedata_sel_m;
  logic [31:0] execute_out_m;
  logic        stall_m;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] reg_writedata_w;
  logic [4:0]  reg_write_addr_w;
  logic        reg_write_en_w;
  logic        mem_misalign_w;
  logic        mem_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        en;
    logic        mis;
  } wb_t;

  wb_t exp_q[$];

  memory_stage #(.MAX_WAIT(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .execute_out_e       (execute_out_e),
    .reg_readdata2_m     (reg_readdata2_m),
    .reg_write_addr_m    (reg_write_addr_m),
    .reg_write_en_m      (reg_write_en_m),
    .dmem_read_en_m      (dmem_read_en_m),
    .dmem_write_en_m     (dmem_write_en_m),
    .reg_writedata_sel_m (reg_writedata_sel_m),
    .execute_out_m       (execute_out_m),
    .stall_m             (stall_m),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .reg_writedata_w     (reg_writedata_w),
    .reg_write_addr_w    (reg_write_addr_w),
    .reg_write_en_w      (reg_write_en_w),
    .mem_misalign_w      (mem_misalign_w),
    .mem_timeout         (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] e, input logic [31:0] sd, input logic [4:0] wa,
                       input logic we, input logic rd, input logic wr, input logic sel);
    execute_out_e       = e;
    reg_readdata2_m     = sd;
    reg_write_addr_m    = wa;
    reg_write_en_m      = we;
    dmem_read_en_m      = rd;
    dmem_write_en_m     = wr;
    reg_writedata_sel_m = sel;
  endtask

  task automatic nop();
    drive(32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] a, input logic en, input logic mis);
    wb_t w;
    w.data = d;
    w.addr = a;
    w.en   = en;
    w.mis  = mis;
    exp_q.push_back(w);
  endtask

  // Scoreboard: every visible write-back or misalign pulse retires the oldest expectation.
  always @(negedge clk) begin
    wb_t w;
    if (rst_n === 1'b1 && (reg_write_en_w === 1'b1 || mem_misalign_w === 1'b1)) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", {27'd0, reg_write_addr_w}, 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("wb_en", {31'd0, reg_write_en_w}, {31'd0, w.en});
        chk("wb_misalign", {31'd0, mem_misalign_w}, {31'd0, w.mis});
        chk("wb_addr", {27'd0, reg_write_addr_w}, {27'd0, w.addr});
        if (w.en) chk("wb_data", reg_writedata_w, w.data);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0000_0000;
    nop();
    tick();
    tick();
    chk("rst_exec_out", execute_out_m, 32'h0);
    chk("rst_stall", {31'd0, stall_m}, 32'h0);
    chk("rst_req", {31'd0, dmem_req}, 32'h0);
    chk("rst_wb_en", {31'd0, reg_write_en_w}, 32'h0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1. ALU op
    drive(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    push(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    tick();
    chk("alu_exec_out", execute_out_m, 32'h0000_1234);
    chk("alu_stall", {31'd0, stall_m}, 32'h0);
    chk("alu_req", {31'd0, dmem_req}, 32'h0);
    nop();
    tick();
    chk("alu_wb_en", {31'd0, reg_write_en_w}, 32'h1);
    chk("alu_wb_data", reg_writedata_w, 32'h0000_1234);

    // 2. Load with same-cycle ack
    drive(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0);
    tick();
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("ld0_req", {31'd0, dmem_req}, 32'h1);
    chk("ld0_we", {31'd0, dmem_we}, 32'h0);
    chk("ld0_addr", dmem_addr, 32'h0000_0100);
    chk("ld0_stall", {31'd0, stall_m}, 32'h0);
    nop();
    tick();
    dmem_ack = 1'b0;
    chk("ld0_wb_data", reg_writedata_w, 32'hDEAD_BEEF);
    tick();

    // 3. Load with 3 wait cycles; upstream changes during stall must be held off
    drive(32'h0000_0104, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h1122_3344, 5'd9, 1'b1, 1'b0);
    tick();
    drive(32'h0000_BAD0, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ld3_stall", {31'd0, stall_m}, 32'h1);
      chk("ld3_req", {31'd0, dmem_req}, 32'h1);
      chk("ld3_addr", dmem_addr, 32'h0000_0104);
      chk("ld3_hold", execute_out_m, 32'h0000_0104);
      tick();
    end
    dmem_ack   = 1'b1;
    dmem_rdata = 32'h1122_3344;
    #1;
    chk("ld3_ack_stall", {31'd0, stall_m}, 32'h0);
    chk("ld3_ack_req", {31'd0, dmem_req}, 32'h1);
    push(32'h0000_BAD0, 5'd3, 1'b1, 1'b0);
    tick();
    dmem_ack = 1'b0;
    nop();
    chk("ld3_next_exec", execute_out_m, 32'h0000_BAD0);
    tick();
    tick();

    // 4. Store (read_en also set: still a store, no register write)
    drive(32'h0000_0200, 32'hCAFE_F00D, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("st_req", {31'd0, dmem_req}, 32'h1);
    chk("st_we", {31'd0, dmem_we}, 32'h1);
    chk("st_wdata", dmem_wdata, 32'hCAFE_F00D);
    chk("st_addr", dmem_addr, 32'h0000_0200);
    chk("st_stall", {31'd0, stall_m}, 32'h0);
    nop();
    tick();
    dmem_ack = 1'b0;
    chk("st_wb_en", {31'd0, reg_write_en_w}, 32'h0);
    tick();

    // 5. Misaligned load
    drive(32'h0000_0102, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    push(32'h0, 5'd6, 1'b0, 1'b1);
    tick();
    chk("mis_req", {31'd0, dmem_req}, 32'h0);
    chk("mis_stall", {31'd0, stall_m}, 32'h0);
    nop();
    tick();
    chk("mis_pulse", {31'd0, mem_misalign_w}, 32'h1);
    chk("mis_wb_en", {31'd0, reg_write_en_w}, 32'h0);
    // Stray ack with nothing outstanding
    dmem_ack = 1'b1;
    #1;
    chk("stray_req", {31'd0, dmem_req}, 32'h0);
    chk("stray_stall", {31'd0, stall_m}, 32'h0);
    tick();
    dmem_ack = 1'b0;
    chk("mis_pulse_end", {31'd0, mem_misalign_w}, 32'h0);

    // 6. Timeout with MAX_WAIT=4
    drive(32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    nop();
    for (int i = 0; i < 4; i++) begin
      chk("to_stall", {31'd0, stall_m}, 32'h1);
      chk("to_req", {31'd0, dmem_req}, 32'h1);
      tick();
    end
    chk("to_release", {31'd0, stall_m}, 32'h0);
    chk("to_flag_pre", {31'd0, mem_timeout}, 32'h0);
    tick();
    chk("to_flag", {31'd0, mem_timeout}, 32'h1);
    chk("to_wb_en", {31'd0, reg_write_en_w}, 32'h0);
    tick();
    chk("to_sticky", {31'd0, mem_timeout}, 32'h1);

    // Reset mid-BUSY
    drive(32'h0000_0304, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    nop();
    tick();
    chk("busy_req", {31'd0, dmem_req}, 32'h1);
    chk("busy_stall", {31'd0, stall_m}, 32'h1);
    rst_n = 1'b0;
    tick();
    chk("rst2_req", {31'd0, dmem_req}, 32'h0);
    chk("rst2_timeout", {31'd0, mem_timeout}, 32'h0);
    chk("rst2_stall", {31'd0, stall_m}, 32'h0);
    chk("rst2_exec_out", execute_out_m, 32'h0);
    rst_n = 1'b1;
    tick();
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
